// File: rtl/mux_4_pkg.sv
// Select-code constants shared by the mux_4 datapath selector and its users.
// The encodings match the operand ports a..d in order.
package mux_4_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_4_comb.sv
// Purely combinational 4:1 selector, full width, no arithmetic on the operands.
// An unknown select drives an unknown result rather than silently picking an operand.
module mux_4_comb
    import mux_4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = 'x;
        case (sel)
            SEL_A: y = a;
            SEL_B: y = b;
            SEL_C: y = c;
            SEL_D: y = d;
        endcase
    end

endmodule

// File: rtl/mux_4.sv
// Registered 4:1 data selector: y holds the operand chosen by sel one clock later.
// y is reloaded every cycle; rst clears it immediately without waiting for clk.
module mux_4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] next;

    mux_4_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel),
        .y  (next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= next;
        end
    end

endmodule

// File: tb/tb_mux_4.sv
// Directed bench for mux_4 at WIDTH 32 and WIDTH 8 sharing clk, rst and sel.
// Expected values are written out by hand and queued per clock step.
module tb_mux_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] a, b, c, d, y;
    logic [7:0]  a8, b8, c8, d8, y8;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    mux_4 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .sel(sel), .y(y)
    );

    mux_4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel), .y(y8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // driver: apply sel, queue the expected outputs, check them one edge later
    task automatic step(input string tag, input logic [1:0] s,
                        input logic [31:0] e32, input logic [7:0] e8);
        sel = s;
        exp_q.push_back(e32);
        exp8_q.push_back(e8);
        @(posedge clk);
        #1;
        check({tag, "_w32"}, y, exp_q.pop_front());
        check({tag, "_w8"}, {24'h0, y8}, {24'h0, exp8_q.pop_front()});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w32"}, y, 32'h0);
        check({tag, "_w8"}, {24'h0, y8}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        sel = 2'b11;
        a = 32'h00000001; b = 32'h00000002; c = 32'h00000003; d = 32'h00000004;
        a8 = 8'hA1; b8 = 8'hB2; c8 = 8'hC3; d8 = 8'hD4;
        #1;

        // load something nonzero so the reset check is meaningful
        step("load_d", 2'b11, 32'h00000004, 8'hD4);

        // asynchronous reset with sel = 11, held across edges
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        @(negedge clk) rst = 1'b0;

        // sweep all four select codes
        step("sel_00", 2'b00, 32'h00000001, 8'hA1);
        step("sel_01", 2'b01, 32'h00000002, 8'hB2);
        step("sel_10", 2'b10, 32'h00000003, 8'hC3);
        step("sel_11", 2'b11, 32'h00000004, 8'hD4);

        // sel change mid-cycle takes effect only at the next edge
        step("lat_a", 2'b00, 32'h00000001, 8'hA1);
        #2 sel = 2'b01;
        #1 check("lat_hold", y, 32'h00000001);
        step("lat_b", 2'b01, 32'h00000002, 8'hB2);

        // operand change under fixed select
        step("opnd_c", 2'b10, 32'h00000003, 8'hC3);
        #2 begin
            c  = 32'hDEADBEEF;
            c8 = 8'h5E;
        end
        #1 check("opnd_hold", y, 32'h00000003);
        step("opnd_new", 2'b10, 32'hDEADBEEF, 8'h5E);

        // mid-operation reset pulse between edges
        step("mid_pre", 2'b01, 32'h00000002, 8'hB2);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        #1 rst = 1'b0;
        #1 check_zero("mid_rel");
        step("mid_post", 2'b01, 32'h00000002, 8'hB2);
        step("mid_next", 2'b00, 32'h00000001, 8'hA1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
